// File: rtl/axi_lite_regbank_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4-Lite register bank.
package axi_lite_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_e;

    function automatic int idx_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/regbank_wstrb_merge.sv
// Byte-lane merge: each byte comes from new data where its strobe is set,
// otherwise from the old value.
module regbank_wstrb_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    output logic [DW-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int k = 0; k < DW / 8; k++) begin
            if (wstrb_i[k]) begin
                merged_o[k*8 +: 8] = wdata_i[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with R/W, read-only status
// and self-clearing pulse registers.
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter logic [NUM_REGS-1:0] PULSE_MASK = '0,
    parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] pulse_o,
    output logic [NUM_REGS-1:0]                    wr_strobe_o
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int SW    = DW / 8;
    localparam int SHIFT = idx_shift(DW);

    logic unused_prot;
    assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot};

    // Ready outputs stay low while reset is held and for the first edge after.
    logic en_q;

    wstate_e         wstate_q, wstate_d;
    logic [AW-1:0]   awaddr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;
    logic [1:0]      bresp_q;

    rstate_e         rstate_q, rstate_d;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      rresp_q;

    logic [DW-1:0]   ctrl_q  [NUM_REGS];
    logic [DW-1:0]   pulse_q [NUM_REGS];
    logic [NUM_REGS-1:0] wstb_q;

    logic            aw_rdy, w_rdy;
    logic            aw_hs, w_hs, ar_hs;
    logic            commit;
    logic [AW-1:0]   c_addr, c_idx;
    logic [DW-1:0]   c_data, c_old, c_merged;
    logic [SW-1:0]   c_strb;
    logic            c_in_range;

    logic [AW-1:0]   ar_idx;
    logic            ar_in_range;
    logic [DW-1:0]   rd_val;

    assign s00_axi_awready = en_q & aw_rdy;
    assign s00_axi_wready  = en_q & w_rdy;
    assign s00_axi_arready = en_q & (rstate_q == R_IDLE);
    assign s00_axi_bvalid  = (wstate_q == W_RESP);
    assign s00_axi_rvalid  = (rstate_q == R_RESP);
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;

    assign aw_hs = s00_axi_awvalid & s00_axi_awready;
    assign w_hs  = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs = s00_axi_arvalid & s00_axi_arready;

    always_comb begin
        wstate_d = wstate_q;
        aw_rdy   = 1'b0;
        w_rdy    = 1'b0;
        commit   = 1'b0;
        c_addr   = awaddr_q;
        c_data   = wdata_q;
        c_strb   = wstrb_q;
        unique case (wstate_q)
            W_IDLE: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                if (aw_hs && w_hs) begin
                    commit   = 1'b1;
                    c_addr   = s00_axi_awaddr;
                    c_data   = s00_axi_wdata;
                    c_strb   = s00_axi_wstrb;
                    wstate_d = W_RESP;
                end else if (aw_hs) begin
                    wstate_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wstate_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                w_rdy = 1'b1;
                if (w_hs) begin
                    commit   = 1'b1;
                    c_data   = s00_axi_wdata;
                    c_strb   = s00_axi_wstrb;
                    wstate_d = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                aw_rdy = 1'b1;
                if (aw_hs) begin
                    commit   = 1'b1;
                    c_addr   = s00_axi_awaddr;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign c_idx      = c_addr >> SHIFT;
    assign c_in_range = (c_idx < AW'(NUM_REGS));

    // Pulse registers merge against zero so the strobe masks the data.
    always_comb begin
        c_old = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (c_idx == AW'(i) && !PULSE_MASK[i]) c_old = ctrl_q[i];
        end
    end

    regbank_wstrb_merge #(
        .DW (DW)
    ) u_merge (
        .old_i    (c_old),
        .wdata_i  (c_data),
        .wstrb_i  (c_strb),
        .merged_o (c_merged)
    );

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            en_q     <= 1'b0;
            wstate_q <= W_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            en_q     <= 1'b1;
            wstate_q <= wstate_d;
            if (wstate_q == W_IDLE && aw_hs) awaddr_q <= s00_axi_awaddr;
            if (wstate_q == W_IDLE && w_hs) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            if (commit) bresp_q <= c_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                ctrl_q[i]  <= RESET_VALUES[i*DW +: DW];
                pulse_q[i] <= '0;
            end
            wstb_q <= '0;
        end else begin
            wstb_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                pulse_q[i] <= '0;
                if (commit && c_in_range && c_idx == AW'(i)) begin
                    wstb_q[i] <= 1'b1;
                    if (!RO_MASK[i]) begin
                        if (PULSE_MASK[i]) pulse_q[i] <= c_merged;
                        else               ctrl_q[i]  <= c_merged;
                    end
                end
            end
        end
    end

    assign ar_idx      = s00_axi_araddr >> SHIFT;
    assign ar_in_range = (ar_idx < AW'(NUM_REGS));

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == AW'(i)) begin
                if (RO_MASK[i])         rd_val = status_i[i*DW +: DW];
                else if (PULSE_MASK[i]) rd_val = '0;
                else                    rd_val = ctrl_q[i];
            end
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        unique case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_RESP;
            R_RESP:  if (s00_axi_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            if (ar_hs) begin
                rdata_q <= ar_in_range ? rd_val : '0;
                rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign ctrl_o[g*DW +: DW]  = ctrl_q[g];
        assign pulse_o[g*DW +: DW] = pulse_q[g];
    end
    assign wr_strobe_o = wstb_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed self-checking bench for axi_lite_regbank.
module tb_axi_lite_regbank;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO_M = 16'h0080;
    localparam logic [NR-1:0] PU_M = 16'h0020;
    localparam logic [NR*DW-1:0] RV =
        {32'hDEADBEEF, {14{32'h0}}, 32'h12345678};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic awvalid = 1'b0;
    logic awready;
    logic [DW-1:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic wvalid = 1'b0;
    logic wready;
    logic [1:0] bresp;
    logic bvalid;
    logic bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic arvalid = 1'b0;
    logic arready;
    logic [DW-1:0] rdata;
    logic [1:0] rresp;
    logic rvalid;
    logic rready = 1'b0;
    logic [NR*DW-1:0] ctrl;
    logic [NR*DW-1:0] status = '0;
    logic [NR*DW-1:0] pulse;
    logic [NR-1:0] wstb;

    int errors = 0;
    int checks = 0;
    int stb_cnt [NR];
    int pulse5_cnt = 0;
    logic [DW-1:0] pulse5_last = '0;

    always #5 clk = ~clk;

    axi_lite_regbank #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR),
        .RO_MASK            (RO_M),
        .PULSE_MASK         (PU_M),
        .RESET_VALUES       (RV)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (3'b000),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (3'b000),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .ctrl_o          (ctrl),
        .status_i        (status),
        .pulse_o         (pulse),
        .wr_strobe_o     (wstb)
    );

    initial for (int i = 0; i < NR; i++) stb_cnt[i] = 0;

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (wstb[i]) stb_cnt[i]++;
        if (pulse[5*DW +: DW] != '0) begin
            pulse5_cnt++;
            pulse5_last = pulse[5*DW +: DW];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs, got = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        resp = 2'bxx;
        for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs) begin w_done = 1; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bvalid) begin got = 1; resp = bresp; end
            tick();
        end
        bready = 1'b0;
        checks++;
        if (!(aw_done && w_done && got)) begin
            errors++;
            $display("FAIL write_timeout addr=%0h", a);
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic [1:0] resp);
        bit hs = 0, got = 0, r;
        araddr = a; arvalid = 1'b1;
        d = 'x; resp = 2'bxx;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk);
            r = arready;
            tick();
            if (r) hs = 1;
        end
        arvalid = 1'b0;
        rready = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (rvalid) begin got = 1; d = rdata; resp = rresp; end
            tick();
        end
        rready = 1'b0;
        checks++;
        if (!(hs && got)) begin
            errors++;
            $display("FAIL read_timeout addr=%0h", a);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 ||
            bresp !== 2'b00 || rresp !== 2'b00 || rdata !== '0) begin
            errors++;
            $display("FAIL %s_handshake got aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h want all 0",
                     tag, awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
        end
        checks++;
        if (ctrl !== RV || pulse !== '0 || wstb !== '0) begin
            errors++;
            $display("FAIL %s_regs ctrl/pulse/strobe differ from reset values (wstb=%h)", tag, wstb);
        end
    endtask

    task automatic test_reset();
        status[7*DW +: DW] = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got aw=%b w=%b ar=%b want 1 1 1", awready, wready, arready);
        end
    endtask

    task automatic test_seq_rw();
        logic [1:0] resp;
        logic [DW-1:0] d, exp;
        for (int i = 0; i < NR; i++) begin
            axi_write(AW'(i * 4), DW'(i + 1), 4'hF, resp);
            checks++;
            if (resp !== 2'b00) begin
                errors++;
                $display("FAIL seq_bresp reg=%0d got %b want 00", i, resp);
            end
        end
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(i * 4), d, resp);
            exp = (i == 5) ? 32'h0 : (i == 7) ? 32'hCAFEF00D : DW'(i + 1);
            checks++;
            if (d !== exp || resp !== 2'b00) begin
                errors++;
                $display("FAIL seq_read reg=%0d got %h/%b want %h/00", i, d, resp, exp);
            end
            exp = (i == 5 || i == 7) ? 32'h0 : DW'(i + 1);
            checks++;
            if (ctrl[i*DW +: DW] !== exp) begin
                errors++;
                $display("FAIL seq_ctrl reg=%0d got %h want %h", i, ctrl[i*DW +: DW], exp);
            end
        end
    endtask

    task automatic test_split();
        int c0 = stb_cnt[2];
        awaddr = 7'd8; awvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL split_awready got %b want 1", awready); end
        tick();
        awvalid = 1'b0;
        repeat (4) tick();
        wdata = 32'h00000A0A; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (wready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL split_aw_first_wait got wready=%b bvalid=%b want 1 0", wready, bvalid);
        end
        tick();
        wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || wstb[2] !== 1'b1) begin
            errors++; $display("FAIL split_aw_first_b got bvalid=%b bresp=%b stb=%b want 1 00 1", bvalid, bresp, wstb[2]);
        end
        bready = 1'b1; tick(); bready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl[2*DW +: DW] !== 32'h00000A0A || bvalid !== 1'b0) begin
            errors++; $display("FAIL split_aw_first_val got %h bvalid=%b want 00000a0a 0", ctrl[2*DW +: DW], bvalid);
        end
        tick();
        wdata = 32'h00000B0B; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (2) tick();
        awaddr = 7'd8; awvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL split_w_first_wait got awready=%b bvalid=%b want 1 0", awready, bvalid);
        end
        tick();
        awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || wstb[2] !== 1'b1) begin
            errors++; $display("FAIL split_w_first_b got bvalid=%b stb=%b want 1 1", bvalid, wstb[2]);
        end
        bready = 1'b1; tick(); bready = 1'b0;
        repeat (2) tick();
        checks++;
        if (ctrl[2*DW +: DW] !== 32'h00000B0B || stb_cnt[2] - c0 != 2) begin
            errors++; $display("FAIL split_w_first_val got %h strobes=%0d want 00000b0b 2", ctrl[2*DW +: DW], stb_cnt[2] - c0);
        end
    endtask

    task automatic test_wstrb();
        logic [1:0] resp;
        logic [DW-1:0] d;
        axi_write(7'd12, 32'hAABBCCDD, 4'hF, resp);
        axi_write(7'd12, 32'h11223344, 4'b0101, resp);
        axi_read(7'd12, d, resp);
        checks++;
        if (d !== 32'hAA22CC44 || resp !== 2'b00) begin
            errors++; $display("FAIL wstrb_merge got %h/%b want aa22cc44/00", d, resp);
        end
    endtask

    task automatic test_pulse();
        logic [1:0] resp;
        logic [DW-1:0] d;
        int p0 = pulse5_cnt;
        axi_write(7'd20, 32'h80000001, 4'hF, resp);
        repeat (3) tick();
        checks++;
        if (pulse5_cnt - p0 != 1 || pulse5_last !== 32'h80000001) begin
            errors++; $display("FAIL pulse_once got cycles=%0d val=%h want 1 80000001", pulse5_cnt - p0, pulse5_last);
        end
        axi_write(7'd20, 32'hFFFFFFFF, 4'b0010, resp);
        repeat (2) tick();
        checks++;
        if (pulse5_last !== 32'h0000FF00) begin
            errors++; $display("FAIL pulse_masked got %h want 0000ff00", pulse5_last);
        end
        axi_read(7'd20, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b00 || ctrl[5*DW +: DW] !== 32'h0) begin
            errors++; $display("FAIL pulse_read got %h/%b ctrl=%h want 0/00/0", d, resp, ctrl[5*DW +: DW]);
        end
    endtask

    task automatic test_ro_and_range();
        logic [1:0] resp;
        logic [DW-1:0] d;
        int s7 = stb_cnt[7];
        axi_write(7'd28, 32'h0, 4'hF, resp);
        tick();
        checks++;
        if (resp !== 2'b00 || stb_cnt[7] - s7 != 1) begin
            errors++; $display("FAIL ro_write got bresp=%b strobes=%0d want 00 1", resp, stb_cnt[7] - s7);
        end
        axi_read(7'd28, d, resp);
        checks++;
        if (d !== 32'hCAFEF00D || resp !== 2'b00) begin
            errors++; $display("FAIL ro_read got %h/%b want cafef00d/00", d, resp);
        end
        axi_write(7'd64, 32'h12345678, 4'hF, resp);
        checks++;
        if (resp !== 2'b10 || ctrl[0 +: DW] !== 32'h1) begin
            errors++; $display("FAIL oor_write got bresp=%b reg0=%h want 10 00000001", resp, ctrl[0 +: DW]);
        end
        axi_read(7'd64, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            errors++; $display("FAIL oor_read got %h/%b want 0/10", d, resp);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp;
        logic [DW-1:0] d;
        int bad = 0;
        awaddr = 7'd16; wdata = 32'h000055AA; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        axi_read(7'd12, d, resp);
        checks++;
        if (d !== 32'hAA22CC44 || resp !== 2'b00) begin
            errors++; $display("FAIL stall_read got %h/%b want aa22cc44/00", d, resp);
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bvalid !== 1'b1 || bresp !== 2'b00) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_bvalid got %0d unstable cycles want 0", bad);
        end
        bready = 1'b1; tick(); bready = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || ctrl[4*DW +: DW] !== 32'h000055AA) begin
            errors++; $display("FAIL stall_done got bvalid=%b reg4=%h want 0 000055aa", bvalid, ctrl[4*DW +: DW]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] resp;
        logic [DW-1:0] d;
        tick();
        awaddr = 7'd24; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        axi_read(7'd0, d, resp);
        checks++;
        if (d !== 32'h12345678 || resp !== 2'b00) begin
            errors++; $display("FAIL after_reset_read got %h/%b want 12345678/00", d, resp);
        end
    endtask

    initial begin
        test_reset();
        test_seq_rw();
        test_split();
        test_wstrb();
        test_pulse();
        test_ro_and_range();
        test_back_to_back();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
